// File: rtl/exhaustive_sweep_sequencer.sv
// Walks a DUT through every N_W-bit input pattern in ascending order and streams
// {vector, sampled output} records to a logger. Optional MISR: SWEEP_SIGNATURE_EN.
module exhaustive_sweep_sequencer #(
  parameter int N_W    = 5,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [N_W-1:0]   dut_n,
  input  logic [OUT_W-1:0] dut_out,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [N_W-1:0]   rec_vec,
  output logic [OUT_W-1:0] rec_out,
  output logic             busy,
  output logic             done,
  output logic [N_W:0]     vec_count
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]      sig
`endif
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EMIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [N_W-1:0]   vec_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             rec_valid_reg, rec_valid_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [N_W-1:0]   rec_vec_reg;
  logic [OUT_W-1:0] rec_out_reg;
  logic [N_W:0]     vec_count_reg;

  logic handshake;
  logic last_vec;
  logic sample_now;

  assign handshake  = (state_reg == ST_EMIT) && rec_ready;
  assign last_vec   = &vec_reg;
  assign sample_now = (state_reg == ST_SETTLE) && (cnt_reg == CNT_ONE);

  // State register; status outputs are registered from the next state so they
  // change cleanly on the same edge as the state itself.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      rec_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rec_valid_reg <= rec_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (sample_now) state_next = ST_EMIT;
        end
        ST_EMIT: begin
          if (rec_ready) state_next = last_vec ? ST_DONE : ST_SETTLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rec_valid_next = (state_next == ST_EMIT);
    busy_next      = (state_next == ST_SETTLE) || (state_next == ST_EMIT);
    done_next      = (state_next == ST_DONE);
  end

  // Datapath: vector, settle counter, record and handshake counter.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      vec_reg       <= '0;
      cnt_reg       <= '0;
      rec_vec_reg   <= '0;
      rec_out_reg   <= '0;
      vec_count_reg <= '0;
    end else if (abort) begin
      vec_reg <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec_reg       <= '0;
            vec_count_reg <= '0;
            cnt_reg       <= SETTLE_LOAD;
          end
        end
        ST_SETTLE: begin
          cnt_reg <= cnt_reg - CNT_ONE;
          if (sample_now) begin
            rec_out_reg <= dut_out;
            rec_vec_reg <= vec_reg;
          end
        end
        ST_EMIT: begin
          if (rec_ready) begin
            vec_count_reg <= vec_count_reg + 1'b1;
            // Terminal vector is caught before the increment, so vec never wraps.
            if (!last_vec) begin
              vec_reg <= vec_reg + 1'b1;
              cnt_reg <= SETTLE_LOAD;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] sig_reg;
  logic [15:0] sig_next;

  always_comb begin
    sig_next = {sig_reg[14:0], 1'b0} ^ (sig_reg[15] ? 16'h1021 : 16'h0000)
             ^ 16'(rec_out_reg);
  end

  // Signature clears on start, accumulates per accepted record, holds on abort.
  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      sig_reg <= '0;
    end else if (!abort) begin
      if ((state_reg == ST_IDLE || state_reg == ST_DONE) && start)
        sig_reg <= '0;
      else if (handshake)
        sig_reg <= sig_next;
    end
  end

  assign sig = sig_reg;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

  assign dut_n     = vec_reg;
  assign rec_valid = rec_valid_reg;
  assign rec_vec   = rec_vec_reg;
  assign rec_out   = rec_out_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign vec_count = vec_count_reg;

endmodule

// File: tb/tb_exhaustive_sweep_sequencer.sv
// Scoreboard bench for exhaustive_sweep_sequencer (N_W=5, SETTLE=1): expected records
// are queued before each sweep and a negedge monitor checks every accepted record.
module tb_exhaustive_sweep_sequencer;

  localparam int N_W    = 5;
  localparam int OUT_W  = 1;
  localparam int SETTLE = 1;

  logic             CK = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [N_W-1:0]   dut_n;
  logic [OUT_W-1:0] dut_out;
  logic             rec_valid;
  logic             rec_ready = 1'b1;
  logic [N_W-1:0]   rec_vec;
  logic [OUT_W-1:0] rec_out;
  logic             busy;
  logic             done;
  logic [N_W:0]     vec_count;
`ifdef SWEEP_SIGNATURE_EN
  logic [15:0]      sig;
`endif

  int checks = 0;
  int failures = 0;
  int model_sel = 0;
  logic [15:0] tb_sig = 16'h0000;
  logic [N_W+OUT_W-1:0] exp_q[$];

  always #5 CK = ~CK;

  exhaustive_sweep_sequencer #(.N_W(N_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .CK(CK),
    .reset(reset),
    .start(start),
    .abort(abort),
    .dut_n(dut_n),
    .dut_out(dut_out),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_vec(rec_vec),
    .rec_out(rec_out),
    .busy(busy),
    .done(done),
    .vec_count(vec_count)
`ifdef SWEEP_SIGNATURE_EN
    ,
    .sig(sig)
`endif
  );

  // DUT-under-test model: parity, constant zero, or a single trigger pattern.
  function automatic logic model_out(input logic [N_W-1:0] v);
    case (model_sel)
      0:       return ^v;
      1:       return 1'b0;
      default: return (v == 5'b10110);
    endcase
  endfunction

  assign dut_out = model_out(dut_n);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic push_sweep();
    logic [N_W-1:0] v;
    tb_sig = 16'h0000;
    for (int i = 0; i < (1 << N_W); i++) begin
      v = N_W'(i);
      exp_q.push_back({v, model_out(v)});
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge CK);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 400) begin
      @(posedge CK);
      #1 n++;
    end
    if (!done) chk({name, "_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic wait_settle_vec(input logic [N_W-1:0] v, input string name);
    int n;
    n = 0;
    while (!(busy && !rec_valid && dut_n == v) && n < 400) begin
      @(posedge CK);
      #1 n++;
    end
    if (n >= 400) chk({name, "_timeout"}, 32'(n), 32'd0);
  endtask

  // Monitor: a record is accepted at the next rising edge when valid&ready here.
  always @(negedge CK) begin
    logic [N_W+OUT_W-1:0] e;
    if (!reset && rec_valid && rec_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL record_unexpected actual vec=%0d out=%0d expected none", rec_vec, rec_out);
      end else begin
        e = exp_q.pop_front();
        if ({rec_vec, rec_out} !== e) begin
          failures++;
          $display("FAIL record actual vec=%0d out=%0d expected vec=%0d out=%0d",
                   rec_vec, rec_out, e[N_W+OUT_W-1:OUT_W], e[OUT_W-1:0]);
        end else begin
          $display("rec  vec=%0d out=%0d", rec_vec, rec_out);
        end
        tb_sig = {tb_sig[14:0], 1'b0} ^ (tb_sig[15] ? 16'h1021 : 16'h0000)
               ^ {{(16-OUT_W){1'b0}}, e[OUT_W-1:0]};
      end
    end
  end

  initial begin
    int n;
    // Reset state
    @(posedge CK);
    #1;
    chk("rst_dut_n", 32'(dut_n), 32'd0);
    chk("rst_rec_valid", 32'(rec_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_vec_count", 32'(vec_count), 32'd0);
    reset = 1'b0;
    repeat (3) @(posedge CK);
    #1 chk("idle_busy", 32'(busy), 32'd0);

    // Full sweep, parity DUT, ready always high; a stray start mid-sweep is ignored
    model_sel = 0;
    push_sweep();
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_dut_n", 32'(dut_n), 32'd0);
    chk("start_rec_valid", 32'(rec_valid), 32'd0);
    n = 0;
    while (!done && n < 400) begin
      @(posedge CK);
      #1 n++;
      start = (n == 20);
    end
    start = 1'b0;
    chk("done_latency", 32'(n), 32'd64);
    chk("sweep_vec_count", 32'(vec_count), 32'd32);
    chk("sweep_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_dut_n", 32'(dut_n), 32'd31);
    chk("done_busy", 32'(busy), 32'd0);
`ifdef SWEEP_SIGNATURE_EN
    chk("sig_parity", 32'(sig), 32'(tb_sig));
`endif

    // start in DONE restarts; stall the logger while record 7 is presented
    push_sweep();
    pulse_start();
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_dut_n", 32'(dut_n), 32'd0);
    chk("restart_vec_count", 32'(vec_count), 32'd0);
    n = 0;
    while (!(rec_valid && rec_vec == 7) && n < 400) begin
      @(posedge CK);
      #1 n++;
    end
    rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CK);
      #1;
      chk("stall_valid", 32'(rec_valid), 32'd1);
      chk("stall_rec_vec", 32'(rec_vec), 32'd7);
      chk("stall_dut_n", 32'(dut_n), 32'd7);
    end
    rec_ready = 1'b1;
    wait_done("stall_sweep", n);
    chk("stall_vec_count", 32'(vec_count), 32'd32);
    chk("stall_queue_empty", 32'(exp_q.size()), 32'd0);

    // abort at vec 10 in SETTLE, then a fresh sweep with a constant-zero DUT
    push_sweep();
    pulse_start();
    wait_settle_vec(5'd10, "abort_wait");
    abort = 1'b1;
    @(posedge CK);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rec_valid", 32'(rec_valid), 32'd0);
    chk("abort_dut_n", 32'(dut_n), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_vec_count", 32'(vec_count), 32'd10);
    exp_q.delete();
    model_sel = 1;
    push_sweep();
    pulse_start();
    wait_done("zero_sweep", n);
    chk("zero_vec_count", 32'(vec_count), 32'd32);
`ifdef SWEEP_SIGNATURE_EN
    chk("sig_zero", 32'(sig), 32'd0);
`endif

    // asynchronous reset mid-sweep at vec 12
    model_sel = 2;
    push_sweep();
    pulse_start();
    wait_settle_vec(5'd12, "reset_wait");
    #2 reset = 1'b1;
    #1;
    chk("async_rst_dut_n", 32'(dut_n), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_valid", 32'(rec_valid), 32'd0);
    chk("async_rst_vec_count", 32'(vec_count), 32'd0);
    exp_q.delete();
    @(posedge CK);
    #1 reset = 1'b0;
    repeat (4) @(posedge CK);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    // single-trigger DUT sweep
    push_sweep();
    pulse_start();
    wait_done("trigger_sweep", n);
    chk("trigger_vec_count", 32'(vec_count), 32'd32);
    chk("trigger_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef SWEEP_SIGNATURE_EN
    chk("sig_trigger", 32'(sig), 32'(tb_sig));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
